// File: rtl/xc_malu_pkg.sv
// xc_malu_pkg: opcodes, packed-width codes, sequencer states and decode helpers
// shared by the XCrypto MALU issue sequencer and its LFSR.
package xc_malu_pkg;

    localparam logic [3:0] OP_DIV    = 4'd0;
    localparam logic [3:0] OP_DIVU   = 4'd1;
    localparam logic [3:0] OP_REM    = 4'd2;
    localparam logic [3:0] OP_REMU   = 4'd3;
    localparam logic [3:0] OP_MUL    = 4'd4;
    localparam logic [3:0] OP_MULU   = 4'd5;
    localparam logic [3:0] OP_MULSU  = 4'd6;
    localparam logic [3:0] OP_CLMUL  = 4'd7;
    localparam logic [3:0] OP_PMUL   = 4'd8;
    localparam logic [3:0] OP_PCLMUL = 4'd9;
    localparam logic [3:0] OP_MADD   = 4'd10;
    localparam logic [3:0] OP_MSUB   = 4'd11;
    localparam logic [3:0] OP_MACC   = 4'd12;
    localparam logic [3:0] OP_MMUL   = 4'd13;

    localparam logic [2:0] PW_32 = 3'd0;
    localparam logic [2:0] PW_16 = 3'd1;
    localparam logic [2:0] PW_8  = 3'd2;
    localparam logic [2:0] PW_4  = 3'd3;
    localparam logic [2:0] PW_2  = 3'd4;

    localparam int          NUM_UOPS  = 14;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_BUSY  = 4'b0010,
        S_RESP  = 4'b0100,
        S_FLUSH = 4'b1000
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MMUL;
    endfunction

    function automatic logic [NUM_UOPS-1:0] op_uop(input logic [3:0] op);
        return op_legal(op) ? (NUM_UOPS'(1) << op) : '0;
    endfunction

    // Unknown width codes fall back to full 32-bit lanes.
    function automatic logic [4:0] pw_onehot(input logic [2:0] pw);
        return (pw <= PW_2) ? (5'b00001 << pw) : 5'b00001;
    endfunction

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/xc_malu_lfsr.sv
// xc_malu_lfsr: 32-bit Galois LFSR that steps only when enabled; supplies
// scrub data used to flush the MALU between instructions.
module xc_malu_lfsr
    import xc_malu_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [31:0] q_o
);

    // An all-zero state would lock up the register, so substitute 1.
    localparam logic [31:0] INIT = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] q_q, q_d;

    always_comb begin
        q_d = en_i ? lfsr_next(q_q) : q_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/xc_malu_issue.sv
// xc_malu_issue: issues one request to the multi-cycle ALU, returns its result,
// then scrubs the MALU with one flush cycle before accepting the next request.
module xc_malu_issue
    import xc_malu_pkg::*;
#(
    parameter int          TIMEOUT      = 256,
    parameter bit          FLUSH_RANDOM = 1'b1,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [3:0]          req_op_i,
    input  logic [2:0]          req_pw_i,
    input  logic [31:0]         req_rs1_i,
    input  logic [31:0]         req_rs2_i,
    input  logic [31:0]         req_rs3_i,
    input  logic                cancel_i,
    output logic                malu_valid_o,
    output logic [NUM_UOPS-1:0] malu_uop_o,
    output logic [4:0]          malu_pw_o,
    output logic [31:0]         malu_rs1_o,
    output logic [31:0]         malu_rs2_o,
    output logic [31:0]         malu_rs3_o,
    output logic                malu_flush_o,
    output logic [31:0]         malu_flush_data_o,
    input  logic [63:0]         malu_result_i,
    input  logic                malu_ready_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [63:0]         rsp_result_o,
    output logic                rsp_err_o
);

    localparam int CW = $clog2(TIMEOUT);

    state_t        state_q, state_d;
    logic [3:0]    op_q;
    logic [2:0]    pw_q;
    logic [31:0]   rs1_q, rs2_q, rs3_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   res_q;
    logic          err_q;
    logic [31:0]   lfsr;
    logic          accept, busy, timeout;

    assign accept  = req_valid_i && (state_q == S_IDLE);
    assign busy    = (state_q == S_BUSY);
    assign timeout = (cnt_q == CW'(TIMEOUT - 1));

    // Cancel is checked first so it wins over a same-cycle ready or handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (req_valid_i) state_d = op_legal(req_op_i) ? S_BUSY : S_RESP;
            S_BUSY:  if (cancel_i) state_d = S_FLUSH;
                     else if (malu_ready_i || timeout) state_d = S_RESP;
            S_RESP:  if (cancel_i || rsp_ready_i) state_d = S_FLUSH;
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result is cleared on accept so error responses always carry zero.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            op_q  <= '0;
            pw_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rs3_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            op_q  <= req_op_i;
            pw_q  <= req_pw_i;
            rs1_q <= req_rs1_i;
            rs2_q <= req_rs2_i;
            rs3_q <= req_rs3_i;
            cnt_q <= '0;
            res_q <= '0;
            err_q <= !op_legal(req_op_i);
        end else if (busy && !cancel_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (malu_ready_i) begin
                res_q <= malu_result_i;
                err_q <= 1'b0;
            end else if (timeout) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
        end
    end

    xc_malu_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clock_i),
        .rst_ni (resetn_i),
        .en_i   (state_q == S_FLUSH),
        .q_o    (lfsr)
    );

    assign req_ready_o       = (state_q == S_IDLE);
    assign malu_valid_o      = busy;
    assign malu_uop_o        = busy ? op_uop(op_q) : '0;
    assign malu_pw_o         = busy ? pw_onehot(pw_q) : '0;
    assign malu_rs1_o        = rs1_q;
    assign malu_rs2_o        = rs2_q;
    assign malu_rs3_o        = rs3_q;
    assign malu_flush_o      = (state_q == S_FLUSH);
    assign malu_flush_data_o = (FLUSH_RANDOM && state_q == S_FLUSH) ? lfsr : '0;
    assign rsp_valid_o       = (state_q == S_RESP);
    assign rsp_result_o      = res_q;
    assign rsp_err_o         = err_q;

endmodule

// File: tb/tb_xc_malu_issue.sv
// tb_xc_malu_issue: scoreboard bench for the MALU issue sequencer; the bench
// plays the MALU and predicts responses and flush data.
module tb_xc_malu_issue;
    import xc_malu_pkg::*;

    localparam int          TO   = 40;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        req_valid = 1'b0, req_ready, cancel = 1'b0;
    logic [3:0]  req_op = '0;
    logic [2:0]  req_pw = '0;
    logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
    logic        malu_valid, malu_flush, malu_ready = 1'b0;
    logic [13:0] malu_uop;
    logic [4:0]  malu_pw;
    logic [31:0] malu_rs1, malu_rs2, malu_rs3, malu_flush_data;
    logic [63:0] malu_result = '0, rsp_result;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;

    typedef struct packed { logic err; logic [63:0] res; } exp_t;
    exp_t        sb[$];
    exp_t        e;
    int          total = 0, bad = 0, cyc = 0;
    logic [31:0] lfsr_m = SEED;

    xc_malu_issue #(.TIMEOUT(TO), .FLUSH_RANDOM(1'b1), .LFSR_SEED(SEED)) dut (
        .clock_i(clk), .resetn_i(resetn), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_pw_i(req_pw), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
        .req_rs3_i(req_rs3), .cancel_i(cancel), .malu_valid_o(malu_valid), .malu_uop_o(malu_uop),
        .malu_pw_o(malu_pw), .malu_rs1_o(malu_rs1), .malu_rs2_o(malu_rs2), .malu_rs3_o(malu_rs3),
        .malu_flush_o(malu_flush), .malu_flush_data_o(malu_flush_data), .malu_result_i(malu_result),
        .malu_ready_i(malu_ready), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Independent reference of the scrub sequence (x^32+x^22+x^2+x+1, shift right).
    function automatic logic [31:0] lfsr_adv(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] pw, input logic [31:0] a, b, c);
        req_valid = 1'b1; req_op = op; req_pw = pw; req_rs1 = a; req_rs2 = b; req_rs3 = c;
        tick;
        req_valid = 1'b0; req_rs1 = '1; req_rs2 = '1; req_rs3 = '1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) tick;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (malu_valid !== 1'b0) begin bad++; $display("FAIL reset_malu_valid got=%b exp=0", malu_valid); end
        total++; if (malu_flush !== 1'b0) begin bad++; $display("FAIL reset_malu_flush got=%b exp=0", malu_flush); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if ({malu_uop, malu_pw} !== 19'h0) begin bad++; $display("FAIL reset_uop_pw got=%h exp=0", {malu_uop, malu_pw}); end
        total++; if ({rsp_result, rsp_err} !== 65'h0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_result, rsp_err}); end
        resetn = 1'b1;
        lfsr_m = SEED;
        tick;
    endtask

    task automatic test_div_stall;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL div_idle_ready got=%b exp=1", req_ready); end
        issue(OP_DIV, PW_8, 32'd100, 32'd7, 32'd0);
        sb.push_back('{err: 1'b0, res: 64'h0000_0002_0000_000E});
        total++; if (malu_valid !== 1'b1) begin bad++; $display("FAIL div_malu_valid got=%b exp=1", malu_valid); end
        total++; if (malu_uop !== 14'h0001) begin bad++; $display("FAIL div_uop got=%h exp=0001", malu_uop); end
        total++; if (malu_pw !== 5'b00100) begin bad++; $display("FAIL div_pw got=%b exp=00100", malu_pw); end
        total++; if ({malu_rs1, malu_rs2} !== {32'd100, 32'd7}) begin bad++; $display("FAIL div_operands got=%h exp=%h", {malu_rs1, malu_rs2}, {32'd100, 32'd7}); end
        malu_ready = 1'b1; malu_result = 64'h0000_0002_0000_000E;
        tick;
        malu_ready = 1'b0; malu_result = 64'hBAD0_BAD0_BAD0_BAD0;
        total++; if (malu_valid !== 1'b0) begin bad++; $display("FAIL div_valid_in_resp got=%b exp=0", malu_valid); end
        for (int i = 0; i < 5; i++) begin
            total++; if ({rsp_valid, rsp_err, rsp_result} !== {1'b1, 1'b0, 64'h0000_0002_0000_000E}) begin bad++; $display("FAIL div_stall%0d got=%b/%b/%h exp=1/0/000000020000000e", i, rsp_valid, rsp_err, rsp_result); end
            tick;
        end
        rsp_ready = 1'b1;
        e = sb.pop_front();
        total++; if ({rsp_err, rsp_result} !== {e.err, e.res}) begin bad++; $display("FAIL div_rsp got=%b/%h exp=%b/%h", rsp_err, rsp_result, e.err, e.res); end
        tick;
        rsp_ready = 1'b0;
        total++; if ({malu_flush, req_ready, rsp_valid} !== 3'b100) begin bad++; $display("FAIL div_flush_state got=%b exp=100", {malu_flush, req_ready, rsp_valid}); end
        total++; if (malu_flush_data !== 32'hACE1_2468) begin bad++; $display("FAIL div_flush_seed got=%h exp=ace12468", malu_flush_data); end
        lfsr_m = lfsr_adv(lfsr_m);
        tick;
        total++; if ({malu_flush, req_ready} !== 2'b01) begin bad++; $display("FAIL div_after_flush got=%b exp=01", {malu_flush, req_ready}); end
    endtask

    task automatic test_mulu;
        int k = 4;
        issue(OP_MULU, PW_32, 32'hFFFF_FFFF, 32'd2, 32'd9);
        sb.push_back('{err: 1'b0, res: 64'h1_FFFF_FFFE});
        total++; if ({malu_uop, malu_pw} !== {14'h0020, 5'b00001}) begin bad++; $display("FAIL mulu_uop_pw got=%h/%b exp=0020/00001", malu_uop, malu_pw); end
        for (int i = 1; i < k; i++) begin
            total++; if ({malu_valid, rsp_valid, malu_rs1} !== {2'b10, 32'hFFFF_FFFF}) begin bad++; $display("FAIL mulu_busy%0d got=%b/%b/%h exp=1/0/ffffffff", i, malu_valid, rsp_valid, malu_rs1); end
            tick;
        end
        malu_ready = 1'b1; malu_result = {32'h0, malu_rs1} * {32'h0, malu_rs2};
        tick;
        malu_ready = 1'b0; malu_result = '0;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mulu_rsp_timing got=%b exp=1", rsp_valid); end
        rsp_ready = 1'b1;
        e = sb.pop_front();
        total++; if ({rsp_err, rsp_result} !== {e.err, e.res}) begin bad++; $display("FAIL mulu_rsp got=%b/%h exp=%b/%h", rsp_err, rsp_result, e.err, e.res); end
        tick;
        rsp_ready = 1'b0;
        total++; if ({malu_flush, malu_flush_data, malu_uop} !== {1'b1, lfsr_m, 14'h0}) begin bad++; $display("FAIL mulu_flush got=%b/%h/%h exp=1/%h/0", malu_flush, malu_flush_data, malu_uop, lfsr_m); end
        lfsr_m = lfsr_adv(lfsr_m);
        tick;
    endtask

    task automatic test_illegal;
        logic [3:0] ops[2] = '{4'd14, 4'd15};
        logic [2:0] pws[2] = '{3'd7, 3'd5};
        for (int i = 0; i < 2; i++) begin
            malu_ready = 1'b1; malu_result = '1;
            issue(ops[i], pws[i], 32'h1234_5678, 32'h9ABC_DEF0, 32'h1);
            sb.push_back('{err: 1'b1, res: 64'h0});
            total++; if ({rsp_valid, malu_valid, malu_uop} !== {2'b10, 14'h0}) begin bad++; $display("FAIL illegal%0d_state got=%b/%b/%h exp=1/0/0", i, rsp_valid, malu_valid, malu_uop); end
            tick;
            malu_ready = 1'b0;
            total++; if ({rsp_valid, malu_valid} !== 2'b10) begin bad++; $display("FAIL illegal%0d_hold got=%b exp=10", i, {rsp_valid, malu_valid}); end
            rsp_ready = 1'b1;
            e = sb.pop_front();
            total++; if ({rsp_err, rsp_result} !== {e.err, e.res}) begin bad++; $display("FAIL illegal%0d_rsp got=%b/%h exp=%b/%h", i, rsp_err, rsp_result, e.err, e.res); end
            tick;
            rsp_ready = 1'b0;
            total++; if ({malu_flush, malu_flush_data} !== {1'b1, lfsr_m}) begin bad++; $display("FAIL illegal%0d_flush got=%b/%h exp=1/%h", i, malu_flush, malu_flush_data, lfsr_m); end
            lfsr_m = lfsr_adv(lfsr_m);
            tick;
        end
    endtask

    task automatic test_cancel;
        issue(OP_MUL, PW_16, 32'd3, 32'd4, 32'd0);
        repeat (2) tick;
        cancel = 1'b1; malu_ready = 1'b1; malu_result = 64'd12;
        tick;
        cancel = 1'b0; malu_ready = 1'b0;
        total++; if ({rsp_valid, malu_valid, malu_flush} !== 3'b001) begin bad++; $display("FAIL cancel_busy got=%b exp=001", {rsp_valid, malu_valid, malu_flush}); end
        total++; if (malu_flush_data !== lfsr_m) begin bad++; $display("FAIL cancel_busy_data got=%h exp=%h", malu_flush_data, lfsr_m); end
        lfsr_m = lfsr_adv(lfsr_m);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        total++; if ({req_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL cancel_idle_after got=%b exp=10", {req_ready, rsp_valid}); end
        issue(OP_MADD, PW_32, 32'd5, 32'd6, 32'd7);
        malu_ready = 1'b1; malu_result = 64'd37;
        tick;
        malu_ready = 1'b0;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL cancel_resp_pre got=%b exp=1", rsp_valid); end
        cancel = 1'b1; rsp_ready = 1'b1;
        tick;
        cancel = 1'b0; rsp_ready = 1'b0;
        total++; if ({rsp_valid, malu_flush, malu_flush_data} !== {2'b01, lfsr_m}) begin bad++; $display("FAIL cancel_resp got=%b/%b/%h exp=0/1/%h", rsp_valid, malu_flush, malu_flush_data, lfsr_m); end
        lfsr_m = lfsr_adv(lfsr_m);
        tick;
        cancel = 1'b1;
        issue(OP_REMU, PW_4, 32'd17, 32'd5, 32'd0);
        cancel = 1'b0;
        sb.push_back('{err: 1'b0, res: 64'h2});
        total++; if ({malu_valid, malu_uop, malu_pw} !== {1'b1, 14'h0008, 5'b01000}) begin bad++; $display("FAIL cancel_idle_ignored got=%b/%h/%b exp=1/0008/01000", malu_valid, malu_uop, malu_pw); end
        tick;
        malu_ready = 1'b1; malu_result = 64'h2;
        tick;
        malu_ready = 1'b0;
        rsp_ready = 1'b1;
        e = sb.pop_front();
        total++; if ({rsp_valid, rsp_err, rsp_result} !== {1'b1, e.err, e.res}) begin bad++; $display("FAIL cancel_idle_rsp got=%b/%b/%h exp=1/%b/%h", rsp_valid, rsp_err, rsp_result, e.err, e.res); end
        tick;
        rsp_ready = 1'b0;
        lfsr_m = lfsr_adv(lfsr_m);
        tick;
    endtask

    task automatic test_timeout;
        int n = 0;
        issue(OP_CLMUL, PW_4, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0);
        sb.push_back('{err: 1'b1, res: 64'h0});
        malu_result = '1;
        while (malu_valid === 1'b1 && n < 200) begin
            n++;
            tick;
        end
        total++; if (n !== TO) begin bad++; $display("FAIL timeout_busy_cycles got=%0d exp=%0d", n, TO); end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL timeout_rsp_valid got=%b exp=1", rsp_valid); end
        rsp_ready = 1'b1;
        e = sb.pop_front();
        total++; if ({rsp_err, rsp_result} !== {e.err, e.res}) begin bad++; $display("FAIL timeout_rsp got=%b/%h exp=%b/%h", rsp_err, rsp_result, e.err, e.res); end
        tick;
        rsp_ready = 1'b0;
        total++; if ({malu_flush, malu_flush_data} !== {1'b1, lfsr_m}) begin bad++; $display("FAIL timeout_flush got=%b/%h exp=1/%h", malu_flush, malu_flush_data, lfsr_m); end
        lfsr_m = lfsr_adv(lfsr_m);
        tick;
    endtask

    task automatic test_back_to_back;
        int t_prev = 0, k_prev = 0, n;
        logic [31:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            n = 0;
            while (req_ready !== 1'b1 && n < 20) begin n++; tick; end
            issue(OP_MULU, PW_32, a, b, 32'd0);
            sb.push_back('{err: 1'b0, res: {32'h0, a} * {32'h0, b}});
            if (i > 0) begin
                total++; if (cyc - t_prev !== k_prev + 3) begin bad++; $display("FAIL b2b%0d_spacing got=%0d exp=%0d", i, cyc - t_prev, k_prev + 3); end
            end
            t_prev = cyc; k_prev = i + 1;
            repeat (i) tick;
            malu_ready = 1'b1; malu_result = {32'h0, malu_rs1} * {32'h0, malu_rs2};
            tick;
            malu_ready = 1'b0; malu_result = '0;
            rsp_ready = 1'b1;
            e = sb.pop_front();
            total++; if ({rsp_valid, rsp_err, rsp_result} !== {1'b1, e.err, e.res}) begin bad++; $display("FAIL b2b%0d_rsp got=%b/%b/%h exp=1/%b/%h", i, rsp_valid, rsp_err, rsp_result, e.err, e.res); end
            tick;
            rsp_ready = 1'b0;
            total++; if ({malu_flush, req_ready, malu_flush_data} !== {2'b10, lfsr_m}) begin bad++; $display("FAIL b2b%0d_flush got=%b/%b/%h exp=1/0/%h", i, malu_flush, req_ready, malu_flush_data, lfsr_m); end
            lfsr_m = lfsr_adv(lfsr_m);
            tick;
        end
    endtask

    task automatic test_async_reset;
        issue(OP_MMUL, PW_2, 32'd1, 32'd2, 32'd3);
        tick;
        #2 resetn = 1'b0;
        #1;
        total++; if ({malu_valid, malu_uop, malu_pw} !== 20'h0) begin bad++; $display("FAIL areset_malu got=%b/%h/%b exp=0", malu_valid, malu_uop, malu_pw); end
        total++; if ({malu_rs1, malu_rs2, malu_rs3} !== 96'h0) begin bad++; $display("FAIL areset_operands got=%h exp=0", {malu_rs1, malu_rs2, malu_rs3}); end
        total++; if ({req_ready, rsp_valid, malu_flush, malu_flush_data} !== {3'b100, 32'h0}) begin bad++; $display("FAIL areset_ctrl got=%b/%b/%b/%h exp=1/0/0/0", req_ready, rsp_valid, malu_flush, malu_flush_data); end
        tick;
        resetn = 1'b1;
        lfsr_m = SEED;
        sb.delete();
        tick;
        total++; if ({req_ready, malu_valid} !== 2'b10) begin bad++; $display("FAIL areset_idle got=%b exp=10", {req_ready, malu_valid}); end
        issue(OP_MSUB, PW_32, 32'd9, 32'd8, 32'd7);
        malu_ready = 1'b1; malu_result = 64'h55;
        tick;
        malu_ready = 1'b0;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        total++; if ({malu_flush, malu_flush_data} !== {1'b1, 32'hACE1_2468}) begin bad++; $display("FAIL areset_lfsr_seed got=%b/%h exp=1/ace12468", malu_flush, malu_flush_data); end
        tick;
    endtask

    initial begin
        test_reset;
        test_div_stall;
        test_mulu;
        test_illegal;
        test_cancel;
        test_timeout;
        test_back_to_back;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
